// File: rtl/grid_to_pixel_mover.sv
// rtl/grid_to_pixel_mover.sv - active piece grid position with pixel glide toward the committed cell
module grid_to_pixel_mover #(
    parameter int X0        = 240,
    parameter int Y0        = 60,
    parameter int CELL      = 20,
    parameter int COLS      = 10,
    parameter int ROWS      = 20,
    parameter int SPAWN_COL = 5
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick,
    input  logic       spawn,
    input  logic       move_left,
    input  logic       move_right,
    input  logic       move_down,
    output logic [4:0] col,
    output logic [4:0] row,
    output logic [9:0] sq2,
    output logic [9:0] sq0,
    output logic       busy,
    output logic       done,
    output logic       at_bottom
);

    typedef enum logic {IDLE, GLIDE} state_t;

    localparam logic [9:0] SPAWN_X  = 10'(X0 + CELL * SPAWN_COL);
    localparam logic [9:0] TOP_Y    = 10'(Y0);
    localparam logic [9:0] STEP     = 10'(CELL);
    localparam logic [4:0] SPAWN_C  = 5'(SPAWN_COL);
    localparam logic [4:0] LAST_COL = 5'(COLS - 1);
    localparam logic [4:0] LAST_ROW = 5'(ROWS - 1);

    state_t     state, state_nxt;
    logic [4:0] col_nxt, row_nxt;
    logic [9:0] sq2_nxt, sq0_nxt;
    logic [9:0] target, target_nxt;
    logic       axis_y, axis_y_nxt;
    logic       dir_neg, dir_neg_nxt;
    logic       busy_nxt, done_nxt;
    logic [9:0] cur, stepped;

    // Only one axis moves per glide; axis_y selects which register steps.
    assign cur     = axis_y ? sq0 : sq2;
    assign stepped = dir_neg ? cur - 10'd1 : cur + 10'd1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        col_nxt     = col;
        row_nxt     = row;
        sq2_nxt     = sq2;
        sq0_nxt     = sq0;
        target_nxt  = target;
        axis_y_nxt  = axis_y;
        dir_neg_nxt = dir_neg;
        busy_nxt    = busy;
        done_nxt    = 1'b0;
        case (state)
            IDLE: begin
                // Priority chain: a blocked higher-priority move swallows lower ones.
                if (spawn) begin
                    col_nxt = SPAWN_C;
                    row_nxt = 5'd0;
                    sq2_nxt = SPAWN_X;
                    sq0_nxt = TOP_Y;
                end else if (move_down) begin
                    if (row < LAST_ROW) begin
                        row_nxt     = row + 5'd1;
                        target_nxt  = sq0 + STEP;
                        axis_y_nxt  = 1'b1;
                        dir_neg_nxt = 1'b0;
                        busy_nxt    = 1'b1;
                        state_nxt   = GLIDE;
                    end
                end else if (move_left) begin
                    if (col > 5'd0) begin
                        col_nxt     = col - 5'd1;
                        target_nxt  = sq2 - STEP;
                        axis_y_nxt  = 1'b0;
                        dir_neg_nxt = 1'b1;
                        busy_nxt    = 1'b1;
                        state_nxt   = GLIDE;
                    end
                end else if (move_right) begin
                    if (col < LAST_COL) begin
                        col_nxt     = col + 5'd1;
                        target_nxt  = sq2 + STEP;
                        axis_y_nxt  = 1'b0;
                        dir_neg_nxt = 1'b0;
                        busy_nxt    = 1'b1;
                        state_nxt   = GLIDE;
                    end
                end
            end
            GLIDE: begin
                if (spawn) begin
                    col_nxt   = SPAWN_C;
                    row_nxt   = 5'd0;
                    sq2_nxt   = SPAWN_X;
                    sq0_nxt   = TOP_Y;
                    busy_nxt  = 1'b0;
                    state_nxt = IDLE;
                end else if (tick) begin
                    if (axis_y) begin
                        sq0_nxt = stepped;
                    end else begin
                        sq2_nxt = stepped;
                    end
                    if (stepped == target) begin
                        busy_nxt  = 1'b0;
                        done_nxt  = 1'b1;
                        state_nxt = IDLE;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            col     <= SPAWN_C;
            row     <= 5'd0;
            sq2     <= SPAWN_X;
            sq0     <= TOP_Y;
            target  <= SPAWN_X;
            axis_y  <= 1'b0;
            dir_neg <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            col     <= col_nxt;
            row     <= row_nxt;
            sq2     <= sq2_nxt;
            sq0     <= sq0_nxt;
            target  <= target_nxt;
            axis_y  <= axis_y_nxt;
            dir_neg <= dir_neg_nxt;
            busy    <= busy_nxt;
            done    <= done_nxt;
        end
    end

    assign at_bottom = (row == LAST_ROW);

endmodule

// File: tb/tb_grid_to_pixel_mover.sv
// tb/tb_grid_to_pixel_mover.sv - directed self-checking bench for grid_to_pixel_mover
module tb_grid_to_pixel_mover;

    logic       clk = 1'b0;
    logic       rst;
    logic       tick;
    logic       spawn;
    logic       move_left;
    logic       move_right;
    logic       move_down;
    logic [4:0] col;
    logic [4:0] row;
    logic [9:0] sq2;
    logic [9:0] sq0;
    logic       busy;
    logic       done;
    logic       at_bottom;

    int errors = 0;
    int checks = 0;

    grid_to_pixel_mover dut (
        .clk        (clk),
        .rst        (rst),
        .tick       (tick),
        .spawn      (spawn),
        .move_left  (move_left),
        .move_right (move_right),
        .move_down  (move_down),
        .col        (col),
        .row        (row),
        .sq2        (sq2),
        .sq0        (sq0),
        .busy       (busy),
        .done       (done),
        .at_bottom  (at_bottom)
    );

    always #5 clk = ~clk;

    // Drive a one-cycle command starting at a negedge; returns at the next negedge.
    task automatic do_cmd(input logic l, input logic r, input logic d, input logic s);
        move_left  = l;
        move_right = r;
        move_down  = d;
        spawn      = s;
        @(negedge clk);
        move_left  = 1'b0;
        move_right = 1'b0;
        move_down  = 1'b0;
        spawn      = 1'b0;
    endtask

    // Wait (bounded) for busy to drop, counting cycles and done pulses, plus one trailing cycle.
    task automatic run_until_idle(output int cyc, output int dn);
        cyc = 0;
        dn  = 0;
        while (busy === 1'b1 && cyc < 200) begin
            @(negedge clk);
            cyc++;
            if (done === 1'b1) dn++;
        end
        @(negedge clk);
        if (done === 1'b1) dn++;
    endtask

    task automatic test_reset;
        rst = 1'b1; tick = 1'b0; spawn = 1'b0;
        move_left = 1'b0; move_right = 1'b0; move_down = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if ({col, row, sq2, sq0, busy, done, at_bottom} !== {5'd5, 5'd0, 10'd340, 10'd60, 3'b000}) begin
            errors++;
            $display("FAIL reset_hold got col=%0d row=%0d sq2=%0d sq0=%0d busy=%b done=%b bot=%b want 5 0 340 60 0 0 0",
                     col, row, sq2, sq0, busy, done, at_bottom);
        end
        rst = 1'b0;
        repeat (5) @(negedge clk);
        checks++;
        if ({col, row, sq2, sq0, busy, done, at_bottom} !== {5'd5, 5'd0, 10'd340, 10'd60, 3'b000}) begin
            errors++;
            $display("FAIL reset_idle got col=%0d row=%0d sq2=%0d sq0=%0d busy=%b done=%b want 5 0 340 60 0 0",
                     col, row, sq2, sq0, busy, done);
        end
    endtask

    task automatic test_move_right;
        int bad;
        tick = 1'b1;
        do_cmd(1'b0, 1'b1, 1'b0, 1'b0);
        checks++;
        if ({col, busy, sq2} !== {5'd6, 1'b1, 10'd340}) begin
            errors++;
            $display("FAIL right_accept got col=%0d busy=%b sq2=%0d want 6 1 340", col, busy, sq2);
        end
        bad = 0;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (i < 20) begin
                if (sq2 !== 10'(340 + i) || busy !== 1'b1 || done !== 1'b0) bad++;
            end else begin
                if (sq2 !== 10'd360 || busy !== 1'b0 || done !== 1'b1) bad++;
            end
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL right_glide_steps got %0d bad cycles want 0 (final sq2=%0d busy=%b done=%b)", bad, sq2, busy, done);
        end
        @(negedge clk);
        checks++;
        if ({done, sq2, sq0, col, row} !== {1'b0, 10'd360, 10'd60, 5'd6, 5'd0}) begin
            errors++;
            $display("FAIL right_settle got done=%b sq2=%0d sq0=%0d col=%0d row=%0d want 0 360 60 6 0",
                     done, sq2, sq0, col, row);
        end
    endtask

    task automatic test_half_tick_down;
        int cyc, dn;
        tick = 1'b0;
        do_cmd(1'b0, 1'b0, 1'b1, 1'b0);
        checks++;
        if ({row, busy} !== {5'd1, 1'b1}) begin
            errors++;
            $display("FAIL down_accept got row=%0d busy=%b want 1 1", row, busy);
        end
        cyc = 0;
        dn  = 0;
        while (busy === 1'b1 && cyc < 200) begin
            tick = (cyc % 2 == 1);
            @(negedge clk);
            cyc++;
            if (done === 1'b1) dn++;
        end
        tick = 1'b1;
        @(negedge clk);
        if (done === 1'b1) dn++;
        checks++;
        if (cyc != 40 || dn != 1 || {sq0, sq2, row, col} !== {10'd80, 10'd360, 5'd1, 5'd6}) begin
            errors++;
            $display("FAIL down_half_tick got cyc=%0d done=%0d sq0=%0d sq2=%0d row=%0d col=%0d want 40 1 80 360 1 6",
                     cyc, dn, sq0, sq2, row, col);
        end
    endtask

    task automatic test_boundaries;
        int cyc, dn;
        tick = 1'b1;
        repeat (6) begin
            do_cmd(1'b1, 1'b0, 1'b0, 1'b0);
            run_until_idle(cyc, dn);
        end
        checks++;
        if ({col, sq2} !== {5'd0, 10'd240}) begin
            errors++;
            $display("FAIL left_edge_reach got col=%0d sq2=%0d want 0 240", col, sq2);
        end
        do_cmd(1'b1, 1'b0, 1'b0, 1'b0);
        run_until_idle(cyc, dn);
        checks++;
        if (cyc != 0 || dn != 0 || {col, sq2, busy} !== {5'd0, 10'd240, 1'b0}) begin
            errors++;
            $display("FAIL left_edge_ignore got cyc=%0d done=%0d col=%0d sq2=%0d busy=%b want 0 0 0 240 0",
                     cyc, dn, col, sq2, busy);
        end
        repeat (9) begin
            do_cmd(1'b0, 1'b1, 1'b0, 1'b0);
            run_until_idle(cyc, dn);
        end
        checks++;
        if ({col, sq2} !== {5'd9, 10'd420}) begin
            errors++;
            $display("FAIL right_edge_reach got col=%0d sq2=%0d want 9 420", col, sq2);
        end
        do_cmd(1'b0, 1'b1, 1'b0, 1'b0);
        run_until_idle(cyc, dn);
        checks++;
        if (cyc != 0 || dn != 0 || {col, sq2, busy} !== {5'd9, 10'd420, 1'b0}) begin
            errors++;
            $display("FAIL right_edge_ignore got cyc=%0d done=%0d col=%0d sq2=%0d busy=%b want 0 0 9 420 0",
                     cyc, dn, col, sq2, busy);
        end
        repeat (18) begin
            do_cmd(1'b0, 1'b0, 1'b1, 1'b0);
            run_until_idle(cyc, dn);
        end
        checks++;
        if ({row, sq0, at_bottom} !== {5'd19, 10'd440, 1'b1}) begin
            errors++;
            $display("FAIL bottom_reach got row=%0d sq0=%0d at_bottom=%b want 19 440 1", row, sq0, at_bottom);
        end
        // Blocked down must also swallow a simultaneous left.
        do_cmd(1'b1, 1'b0, 1'b1, 1'b0);
        run_until_idle(cyc, dn);
        checks++;
        if (cyc != 0 || dn != 0 || {row, col, sq0, sq2, busy} !== {5'd19, 5'd9, 10'd440, 10'd420, 1'b0}) begin
            errors++;
            $display("FAIL bottom_ignore got cyc=%0d done=%0d row=%0d col=%0d sq0=%0d sq2=%0d busy=%b want 0 0 19 9 440 420 0",
                     cyc, dn, row, col, sq0, sq2, busy);
        end
    endtask

    task automatic test_priority;
        int cyc, dn;
        tick = 1'b1;
        do_cmd(1'b0, 1'b0, 1'b0, 1'b1);
        checks++;
        if ({col, row, sq2, sq0, busy, done, at_bottom} !== {5'd5, 5'd0, 10'd340, 10'd60, 3'b000}) begin
            errors++;
            $display("FAIL spawn_idle got col=%0d row=%0d sq2=%0d sq0=%0d busy=%b done=%b bot=%b want 5 0 340 60 0 0 0",
                     col, row, sq2, sq0, busy, done, at_bottom);
        end
        do_cmd(1'b1, 1'b0, 1'b1, 1'b0);
        checks++;
        if ({row, col, busy} !== {5'd1, 5'd5, 1'b1}) begin
            errors++;
            $display("FAIL down_over_left got row=%0d col=%0d busy=%b want 1 5 1", row, col, busy);
        end
        do_cmd(1'b0, 1'b1, 1'b0, 1'b0);
        do_cmd(1'b1, 1'b0, 1'b0, 1'b0);
        do_cmd(1'b0, 1'b0, 1'b1, 1'b0);
        run_until_idle(cyc, dn);
        checks++;
        if (cyc != 17 || dn != 1 || {row, col, sq2, sq0} !== {5'd1, 5'd5, 10'd340, 10'd80}) begin
            errors++;
            $display("FAIL busy_drop got cyc=%0d done=%0d row=%0d col=%0d sq2=%0d sq0=%0d want 17 1 1 5 340 80",
                     cyc, dn, row, col, sq2, sq0);
        end
    endtask

    task automatic test_spawn_abort;
        int dn;
        tick = 1'b1;
        do_cmd(1'b0, 1'b1, 1'b0, 1'b0);
        repeat (9) @(negedge clk);
        checks++;
        if ({sq2, busy, col} !== {10'd349, 1'b1, 5'd6}) begin
            errors++;
            $display("FAIL abort_mid got sq2=%0d busy=%b col=%0d want 349 1 6", sq2, busy, col);
        end
        do_cmd(1'b0, 1'b0, 1'b0, 1'b1);
        dn = (done === 1'b1) ? 1 : 0;
        checks++;
        if ({col, row, sq2, sq0, busy} !== {5'd5, 5'd0, 10'd340, 10'd60, 1'b0}) begin
            errors++;
            $display("FAIL abort_snap got col=%0d row=%0d sq2=%0d sq0=%0d busy=%b want 5 0 340 60 0",
                     col, row, sq2, sq0, busy);
        end
        repeat (3) begin
            @(negedge clk);
            if (done === 1'b1) dn++;
        end
        checks++;
        if (dn != 0 || busy !== 1'b0 || sq2 !== 10'd340) begin
            errors++;
            $display("FAIL abort_no_done got done_count=%0d busy=%b sq2=%0d want 0 0 340", dn, busy, sq2);
        end
    endtask

    task automatic test_reset_mid_glide;
        int dn;
        tick = 1'b1;
        do_cmd(1'b0, 1'b0, 1'b1, 1'b0);
        repeat (5) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({col, row, sq2, sq0, busy, done} !== {5'd5, 5'd0, 10'd340, 10'd60, 2'b00}) begin
            errors++;
            $display("FAIL reset_async got col=%0d row=%0d sq2=%0d sq0=%0d busy=%b done=%b want 5 0 340 60 0 0",
                     col, row, sq2, sq0, busy, done);
        end
        @(negedge clk);
        rst = 1'b0;
        dn = 0;
        repeat (25) begin
            @(negedge clk);
            if (done === 1'b1 || busy === 1'b1) dn++;
        end
        checks++;
        if (dn != 0 || {row, sq0} !== {5'd0, 10'd60}) begin
            errors++;
            $display("FAIL reset_no_resume got activity=%0d row=%0d sq0=%0d want 0 0 60", dn, row, sq0);
        end
    endtask

    initial begin
        rst = 1'b1;
        tick = 1'b0; spawn = 1'b0;
        move_left = 1'b0; move_right = 1'b0; move_down = 1'b0;
        @(negedge clk);
        test_reset;
        test_move_right;
        test_half_tick_down;
        test_boundaries;
        test_priority;
        test_spawn_abort;
        test_reset_mid_glide;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
